// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake, status pulses and PS/2 pad signals of the
// host-to-device PS/2 transmitter. The slave modport is the transmitter side.
// The master modport is the side that requests bytes and models the pads.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. It sends one byte (data LSB
// first, odd parity, stop) to the keyboard through open-drain pads.
// The sequence is: inhibit the clock, request to send, shift the bits on
// device clock falls, then sample the ACK and wait for an idle bus.
// Optional feature: define PS2_TX_TIMEOUT_EN to add a per-frame watchdog. It
// aborts a frame that stalls in SEND, ACK or WAIT_IDLE for TIMEOUT_CYCLES.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned SETUP_CYCLES   = 100,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);

    // One counter times both the inhibit and the setup phase.
    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e             state_q, state_d;
    logic               clk_meta_q, clk_meta_d;
    logic               clk_sync_q, clk_sync_d;
    logic               clk_prev_q, clk_prev_d;
    logic               data_meta_q, data_meta_d;
    logic               data_sync_q, data_sync_d;
    logic [8:0]         shreg_q, shreg_d;      // {parity, data}, shifted out LSB first
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
    logic               data_oe_q, data_oe_d;
    logic               nack_q, nack_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic idle;
    logic accept;
    logic fall;
    logic timeout;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle & bus.tx_valid;
    assign fall   = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              in_frame;

    // Count cycles in the device-clocked part of the frame; flag the limit.
    always_comb begin
        in_frame = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
        timeout  = in_frame && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
        wdog_d   = (in_frame && (state_d != S_IDLE)) ? wdog_q + WDOG_W'(1) : '0;
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // The watchdog limit has no effect when there is no watchdog.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // Next-state, datapath and output-pulse logic for the frame sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first. Otherwise a
        // branch that skips an assignment infers a latch.
        state_d     = state_q;
        clk_meta_d  = bus.ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = bus.ps2_data_in;
        data_sync_d = data_meta_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        phase_cnt_d = phase_cnt_q;
        data_oe_d   = data_oe_q;
        nack_d      = nack_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d     = {~^bus.tx_data, bus.tx_data};
                    bitcnt_d    = '0;
                    phase_cnt_d = '0;
                    nack_d      = 1'b0;
                    state_d     = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (phase_cnt_q == PHASE_W'(INHIBIT_CYCLES - 1)) begin
                    phase_cnt_d = '0;
                    data_oe_d   = 1'b1;          // start bit
                    state_d     = S_REQ;
                end else begin
                    phase_cnt_d = phase_cnt_q + PHASE_W'(1);
                end
            end

            S_REQ: begin
                if (phase_cnt_q == PHASE_W'(SETUP_CYCLES - 1)) begin
                    phase_cnt_d = '0;
                    bitcnt_d    = '0;
                    state_d     = S_SEND;
                end else begin
                    phase_cnt_d = phase_cnt_q + PHASE_W'(1);
                end
            end

            S_SEND: begin
                if (fall) begin
                    if (bitcnt_q == 4'd9) begin
                        data_oe_d = 1'b0;        // release for the stop bit
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[8:1]};
                        bitcnt_d  = bitcnt_q + 4'd1;
                    end
                end
            end

            S_ACK: begin
                if (fall) begin
                    nack_d  = data_sync_q;       // device holds data low to ACK
                    state_d = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    state_d = S_IDLE;
                end
            end

            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // A stalled frame is abandoned with both lines released.
        if (timeout) begin
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = S_IDLE;
        end
    end

    // State register. Synchronous reset returns to IDLE with both lines released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            // NOTE: the synchronizers reset to 1, the idle bus level. This
            // stops the first cycle after reset from showing a fake falling edge.
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            phase_cnt_q <= '0;
            data_oe_q   <= 1'b0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here. Every flop then samples
            // the pre-edge values, whatever the order of the statements.
            state_q     <= state_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            phase_cnt_q <= phase_cnt_d;
            data_oe_q   <= data_oe_d;
            nack_q      <= nack_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_ready    = idle;
    assign bus.tx_busy     = ~idle;
    assign bus.tx_done     = done_q;
    assign bus.tx_err      = err_q;
    assign bus.ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign bus.ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx.
// A device model clocks each frame in through open-drain pads. Each frame's
// received bits are compared with {stop, odd parity, data}, which a small
// model computes from the byte.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int SET = 8;
    localparam int TMO = 5000;

    typedef struct {
        logic [7:0] data;
        bit         nack;
        bit         exp_par;
        bit         exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_line, data_line;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    ps2_host_tx_if bus ();

    assign clk_line        = ~(bus.ps2_clk_oe | dev_clk_low);
    assign data_line       = ~(bus.ps2_data_oe | dev_data_low);
    assign bus.ps2_clk_in  = clk_line;
    assign bus.ps2_data_in = data_line;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_done) done_cnt <= done_cnt + 1;
        if (bus.tx_err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish within 100000 cycles");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: the odd parity bit makes the total count of ones odd.
    function automatic bit model_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Call this at the first negedge in INHIBIT. It counts the inhibit and
    // setup cycles and returns at the first SEND cycle.
    task automatic measure_phases(input string tag);
        int inh = 0;
        int setup = 0;
        while (bus.ps2_clk_oe && !bus.ps2_data_oe && inh < INH + 50) begin
            inh++;
            @(negedge clk);
        end
        while (bus.ps2_clk_oe && bus.ps2_data_oe && setup < SET + 50) begin
            setup++;
            @(negedge clk);
        end
        check({tag, "_inhibit_len"}, inh, INH);
        check({tag, "_setup_len"}, setup, SET);
        check({tag, "_send_lines"}, {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b01);
    endtask

    // Device model. It clocks n_falls falling edges and samples data just
    // before each rising edge. Fall 11 is the ACK clock, with data held low
    // unless nack is set.
    task automatic bfm(input int h, input bit nack, input int n_falls, output logic [9:0] seen);
        seen = '0;
        wait_cyc(h);
        for (int i = 0; i < n_falls; i++) begin
            if (i == 10) begin
                dev_data_low = ~nack;
                wait_cyc(h);
            end
            dev_clk_low = 1'b1;
            wait_cyc(h);
            if (i < 10) seen[i] = data_line;
            dev_clk_low = 1'b0;
            if (i < 10) wait_cyc(h);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit exp_err);
        int t = 0;
        while (!bus.tx_done && t < 200) begin
            t++;
            @(negedge clk);
        end
        check({tag, "_done"}, bus.tx_done, 1'b1);
        check({tag, "_err"}, bus.tx_err, exp_err);
        check({tag, "_ready_with_done"}, bus.tx_ready, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] data, input bit nack,
                             input int h, input bit exp_par, input bit exp_err);
        int t = 0;
        int d0, e0;
        logic [9:0] seen;
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && t < 1000) begin
            t++;
            @(negedge clk);
        end
        check({tag, "_ready"}, bus.tx_ready, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~data;
        check({tag, "_busy"}, bus.tx_busy, 1'b1);
        measure_phases(tag);
        bfm(h, nack, 11, seen);
        check({tag, "_bits"}, seen, {1'b1, exp_par, data});
        wait_done(tag, exp_err);
        @(negedge clk);
        check({tag, "_done_one_pulse"}, done_cnt - d0, 1);
        check({tag, "_err_pulses"}, err_cnt - e0, exp_err ? 1 : 0);
        check({tag, "_lines_idle"}, {bus.tx_busy, bus.ps2_clk_oe, bus.ps2_data_oe}, 3'b000);
    endtask

    initial begin
        vec_t vecs [5];
        logic [9:0] seen;
        int d0, t, t0;

        vecs[0] = '{data: 8'hED, nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'h00, nack: 1'b1, exp_par: 1'b1, exp_err: 1'b1};
        vecs[2] = '{data: 8'hFF, nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
        vecs[3] = '{data: 8'h01, nack: 1'b1, exp_par: 1'b0, exp_err: 1'b1};
        vecs[4] = '{data: 8'h80, nack: 1'b0, exp_par: 1'b0, exp_err: 1'b0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset held for three cycles.
        reset = 1'b1;
        wait_cyc(3);
        check("reset_ready", bus.tx_ready, 1'b1);
        check("reset_busy", bus.tx_busy, 1'b0);
        check("reset_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        check("reset_pulses", {bus.tx_done, bus.tx_err}, 2'b00);
        reset = 1'b0;
        wait_cyc(5);
        check("idle_no_done", done_cnt, 0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].nack, 8,
                      vecs[i].exp_par, vecs[i].exp_err);

        // Random frames checked against the parity model.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            bit nk;
            int h;
            d  = 8'($urandom_range(0, 255));
            nk = 1'($urandom_range(0, 1));
            h  = int'($urandom_range(6, 14));
            run_frame($sformatf("rnd%0d", i), d, nk, h, model_parity(d), nk);
        end

        // Back-to-back: tx_valid stays high, and the second byte is accepted in the tx_done cycle.
        bus.tx_data  = 8'hED;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'h02;
        measure_phases("b2b_first");
        bfm(9, 1'b0, 11, seen);
        check("b2b_first_bits", seen, {1'b1, 1'b1, 8'hED});
        wait_done("b2b_first", 1'b0);
        @(negedge clk);
        check("b2b_second_accepted", {bus.tx_busy, bus.ps2_clk_oe}, 2'b11);
        bus.tx_valid = 1'b0;
        measure_phases("b2b_second");
        bfm(9, 1'b0, 11, seen);
        check("b2b_second_bits", seen, {1'b1, 1'b0, 8'h02});
        wait_done("b2b_second", 1'b0);

        // Reset after the 4th device falling edge, then a fresh frame.
        wait_cyc(3);
        d0 = done_cnt;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        measure_phases("abort");
        bfm(8, 1'b0, 4, seen);
        check("abort_bits_so_far", seen[3:0], 4'hC);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", {bus.tx_ready, bus.tx_busy}, 2'b10);
        check("abort_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        reset = 1'b0;
        wait_cyc(2);
        check("abort_no_done", done_cnt - d0, 0);
        run_frame("after_abort", 8'hF4, 1'b0, 8, 1'b0, 1'b0);

        // Silent device: the frame stalls in SEND.
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        d0 = done_cnt;
        measure_phases("silent");
        t0 = cyc;
`ifdef PS2_TX_TIMEOUT_EN
        t = 0;
        while (!bus.tx_done && t < TMO + 100) begin
            t++;
            @(negedge clk);
        end
        check("timeout_done", bus.tx_done, 1'b1);
        check("timeout_err", bus.tx_err, 1'b1);
        check("timeout_latency", cyc - t0, TMO);
        check("timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        check("timeout_ready", bus.tx_ready, 1'b1);
`else
        t = 0;
        wait_cyc(TMO + 1000);
        check("silent_still_busy", bus.tx_busy, 1'b1);
        check("silent_no_done", done_cnt - d0, 0);
        check("silent_waited", cyc - t0, TMO + 1000 + t);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("silent_reset_idle", bus.tx_ready, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
